// File: rtl/despachante_clusters_pkg.sv
// Shared constants and types for the cluster dispatcher.
// Sizes the candidate-buffer entry fields and the FSM states.
package pkg_clusters;

    localparam int NUM_CLUSTERS  = 5;
    localparam int TAM_ENDERECO  = 64;
    localparam int TAM_HASH_DOIS = 8;
    localparam int CW            = $clog2(NUM_CLUSTERS);

    typedef enum logic [2:0] {
        OCIOSO,
        CAPTURA,
        ENVIA,
        AGUARDA,
        LIBERA
    } estado_despachante_t;

endpackage

// File: rtl/despachante_clusters_if.sv
// Probe request/response channel between the dispatcher and the clusters.
// master = dispatcher side, slave = cluster side.
interface despachante_clusters_if;
    import pkg_clusters::*;

    logic                     req_valido;
    logic                     req_pronto;
    logic [CW-1:0]            req_cluster;
    logic [TAM_ENDERECO-1:0]  req_endereco;
    logic [TAM_HASH_DOIS-1:0] req_hash;
    logic                     resp_valido;
    logic                     resp_acerto;

    modport master (
        output req_valido,
        output req_cluster,
        output req_endereco,
        output req_hash,
        input  req_pronto,
        input  resp_valido,
        input  resp_acerto
    );

    modport slave (
        input  req_valido,
        input  req_cluster,
        input  req_endereco,
        input  req_hash,
        output req_pronto,
        output resp_valido,
        output resp_acerto
    );

endinterface

// File: rtl/despachante_clusters_seletor.sv
// Lowest-set-bit selector: index of the first pending cluster.
// valido is low when no bit is set (index then reads 0).
module seletor_menor_bit #(
    parameter int NUM_CLUSTERS = 5,
    localparam int CW = $clog2(NUM_CLUSTERS)
) (
    input  logic [NUM_CLUSTERS-1:0] bits,
    output logic [CW-1:0]           indice,
    output logic                    valido
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        indice = '0;
        valido = |bits;
        for (int i = NUM_CLUSTERS - 1; i >= 0; i--) begin
            if (bits[i]) begin
                indice = CW'(i);
            end
        end
    end

endmodule

// File: rtl/despachante_clusters.sv
// Candidate-buffer consumer: probes each flagged cluster in turn,
// writes the shrinking bitmap back and retires the entry with one result.
module despachante_clusters
    import pkg_clusters::*;
#(
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     entrada_valida,
    input  logic [NUM_CLUSTERS-1:0]  bitmap_atual,
    input  logic [TAM_ENDERECO-1:0]  endereco_atual,
    input  logic [TAM_HASH_DOIS-1:0] hash_atual,
    output logic [NUM_CLUSTERS-1:0]  bitmap_atualizado,
    output logic                     zero,
    despachante_clusters_if.master   cl,
    output logic                     res_valido,
    output logic                     res_acerto,
    output logic [CW-1:0]            res_cluster,
    output logic [TAM_ENDERECO-1:0]  res_endereco,
    output logic [15:0]              timeouts
);

    localparam int CNT_W = $clog2(TIMEOUT_CICLOS);

    estado_despachante_t estado;
    estado_despachante_t prox;

    logic [NUM_CLUSTERS-1:0]  trabalho;
    logic [NUM_CLUSTERS-1:0]  trabalho_limpo;
    logic [TAM_ENDERECO-1:0]  endereco_lat;
    logic [TAM_HASH_DOIS-1:0] hash_lat;
    logic [CNT_W-1:0]         cnt;
    logic [CW-1:0]            indice;
    logic                     tem_bit;
    logic                     expirou;
    logic                     acerto_agora;

    seletor_menor_bit #(
        .NUM_CLUSTERS(NUM_CLUSTERS)
    ) u_seletor (
        .bits   (trabalho),
        .indice (indice),
        .valido (tem_bit)
    );

    // Probe bookkeeping: bitmap without the probed bit, hit and expiry flags.
    always_comb begin
        trabalho_limpo = trabalho & ~(NUM_CLUSTERS'(1) << indice);
        acerto_agora   = cl.resp_valido && cl.resp_acerto;
        expirou        = !cl.resp_valido
                         && (cnt == CNT_W'(TIMEOUT_CICLOS - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    // Next-state logic; a response beats an expiring counter.
    always_comb begin
        prox = estado;
        unique case (estado)
            OCIOSO: begin
                if (entrada_valida) prox = CAPTURA;
            end
            CAPTURA: begin
                prox = tem_bit ? ENVIA : LIBERA;
            end
            ENVIA: begin
                if (cl.req_pronto) prox = AGUARDA;
            end
            AGUARDA: begin
                if (acerto_agora) begin
                    prox = LIBERA;
                end else if (cl.resp_valido || expirou) begin
                    prox = (trabalho_limpo != '0) ? ENVIA : LIBERA;
                end
            end
            LIBERA: begin
                prox = OCIOSO;
            end
            default: begin
                prox = OCIOSO;
            end
        endcase
    end

    // Moore outputs; the buffer sees its own bitmap only while idle.
    always_comb begin
        cl.req_valido     = (estado == ENVIA);
        cl.req_cluster    = indice;
        cl.req_endereco   = endereco_lat;
        cl.req_hash       = hash_lat;
        zero              = (estado == LIBERA);
        res_valido        = (estado == LIBERA);
        bitmap_atualizado = (estado == OCIOSO) ? bitmap_atual : trabalho;
    end

    // Entry latch, working bitmap and response wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            trabalho     <= '0;
            endereco_lat <= '0;
            hash_lat     <= '0;
            cnt          <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (entrada_valida) begin
                        trabalho     <= bitmap_atual;
                        endereco_lat <= endereco_atual;
                        hash_lat     <= hash_atual;
                    end
                end
                ENVIA: begin
                    if (cl.req_pronto) cnt <= '0;
                end
                AGUARDA: begin
                    cnt <= cnt + 1'b1;
                    if (acerto_agora) begin
                        trabalho <= '0;
                    end else if (cl.resp_valido || expirou) begin
                        trabalho <= trabalho_limpo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result register, loaded on the way into LIBERA.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_acerto   <= 1'b0;
            res_cluster  <= '0;
            res_endereco <= '0;
        end else if (prox == LIBERA && estado != LIBERA) begin
            res_acerto   <= (estado == AGUARDA) && acerto_agora;
            res_cluster  <= ((estado == AGUARDA) && acerto_agora)
                            ? indice : '0;
            res_endereco <= endereco_lat;
        end
    end

    // Saturating count of probes that never got a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeouts <= '0;
        end else if (estado == AGUARDA && expirou
                     && timeouts != 16'hFFFF) begin
            timeouts <= timeouts + 16'd1;
        end
    end

endmodule
